// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, halt opcode and fetch FSM state type
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] HALT_INSTR = 32'h0000_0063;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC + FSM + IF/ID register; pc->imem, instr<-imem, redirect in, out_* valid/ready to decode, halted/misalign_err status
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP = 64'd8,
  parameter bit HALT_DETECT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  input  logic [ILEN-1:0] instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic            halted,
  output logic            misalign_err
);
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, out_pc_q, out_pc_d;
  logic [ILEN-1:0] out_instr_q, out_instr_d;
  logic out_valid_q, out_valid_d, halted_q, halted_d, misalign_q, misalign_d;
  logic capture, is_halt;
  always_comb begin
    capture = (state_q == RUN) && (!out_valid_q || out_ready);
    is_halt = HALT_DETECT && (instr == HALT_INSTR);
    state_d = state_q;
    pc_d = pc_q;
    out_pc_d = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    halted_d = halted_q;
    misalign_d = misalign_q;
    if (redirect_valid) begin
      pc_d = {redirect_target[XLEN-1:3], 3'b000};
      out_valid_d = 1'b0;
      state_d = RUN;
      halted_d = 1'b0;
      misalign_d = misalign_q | (|redirect_target[2:0]);
    end else if (state_q == IDLE) begin
      state_d = RUN;
    end else if (capture) begin
      out_pc_d = pc_q;
      out_instr_d = instr;
      out_valid_d = 1'b1;
      pc_d = is_halt ? pc_q : pc_q + PC_STEP;
      state_d = is_halt ? HALT : RUN;
      halted_d = is_halt;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      out_pc_q <= '0;
      out_instr_q <= '0;
      out_valid_q <= 1'b0;
      halted_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_pc_q <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
      halted_q <= halted_d;
      misalign_q <= misalign_d;
    end
  end
  assign pc = pc_q;
  assign out_valid = out_valid_q;
  assign out_pc = out_pc_q;
  assign out_instr = out_instr_q;
  assign halted = halted_q;
  assign misalign_err = misalign_q;
endmodule
